// File: rtl/clock_pkg.sv
// Shared encodings, limits and field widths for the 12-hour time-of-day controller.
package clock_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HRS  = 2'd1,
        SET_MINS = 2'd2
    } state_t;

    localparam int MAX_SEC = 59;
    localparam int MAX_MIN = 59;
    localparam int MAX_HR  = 11;

    localparam int HR_W = 4;
    localparam int MS_W = 6;

    // Wrapping increment; anything at or above the limit (including corrupt values) loads 0.
    function automatic logic [MS_W-1:0] ms_next(input logic [MS_W-1:0] v, input int max);
        return (int'(v) >= max) ? '0 : v + 1'b1;
    endfunction

    function automatic logic [HR_W-1:0] hr_next(input logic [HR_W-1:0] v);
        return (int'(v) >= MAX_HR) ? '0 : v + 1'b1;
    endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Front-panel buttons in, time/mode/strobe outputs out; slave side is the controller.
interface clock_set_ctrl_if;
    import clock_pkg::*;

    logic            btn_mode;
    logic            btn_inc;
    logic [HR_W-1:0] hrs;
    logic [MS_W-1:0] mins;
    logic [MS_W-1:0] secs;
    logic            pm;
    logic            set_hrs;
    logic            set_mins;
    logic            tick;

    modport slave (
        input  btn_mode, btn_inc,
        output hrs, mins, secs, pm, set_hrs, set_mins, tick
    );

    modport master (
        output btn_mode, btn_inc,
        input  hrs, mins, secs, pm, set_hrs, set_mins, tick
    );

endinterface

// File: rtl/tick_gen.sv
// Prescaler producing a registered one-cycle strobe every TICK_DIV clocks; i_clr restarts the count.
module tick_gen #(
    parameter int TICK_DIV = 50000000,
    parameter int CNT_W    = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    output logic o_tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_tick;

    // NOTE: assign the default first so every path through always_comb drives w_cnt_nxt (no latch).
    always_comb begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (i_clr || (r_cnt == LAST)) begin
            w_cnt_nxt = '0;
        end
    end

    // Tick is registered from the next count so it is high exactly while r_cnt == LAST.
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_tick <= (w_cnt_nxt == LAST);
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/clock_set_ctrl.sv
// 12-hour time-of-day controller: button edge detect, RUN/SET_HRS/SET_MINS sequencing and
// the hh:mm:ss/AM-PM counters, all outputs registered.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int TICK_DIV = 50000000,
    parameter int CNT_W    = 26
) (
    input  logic clk,
    input  logic rst,
    clock_set_ctrl_if.slave bus
);

    state_t          r_state;
    logic            r_mode_d;
    logic            r_inc_d;
    logic [HR_W-1:0] r_hrs;
    logic [MS_W-1:0] r_mins;
    logic [MS_W-1:0] r_secs;
    logic            r_pm;
    logic            r_set_hrs;
    logic            r_set_mins;

    logic w_mode_p;
    logic w_inc_p;
    logic w_tick;
    logic w_enter_run;

    assign w_mode_p = bus.btn_mode & ~r_mode_d;
    assign w_inc_p  = bus.btn_inc  & ~r_inc_d;

    // Any transition into RUN restarts the prescaler so the first second is a full one.
    always_comb begin
        w_enter_run = 1'b0;
        case (r_state)
            RUN:      w_enter_run = 1'b0;
            SET_HRS:  w_enter_run = 1'b0;
            SET_MINS: w_enter_run = w_mode_p;
            default:  w_enter_run = 1'b1;
        endcase
    end

    tick_gen #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_enter_run),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= RUN;
            r_mode_d   <= 1'b0;
            r_inc_d    <= 1'b0;
            r_hrs      <= '0;
            r_mins     <= '0;
            r_secs     <= '0;
            r_pm       <= 1'b0;
            r_set_hrs  <= 1'b0;
            r_set_mins <= 1'b0;
        end else begin
            r_mode_d <= bus.btn_mode;
            r_inc_d  <= bus.btn_inc;

            case (r_state)
                RUN: begin
                    if (w_tick) begin
                        r_secs <= ms_next(r_secs, MAX_SEC);
                        if (r_secs == MS_W'(MAX_SEC)) begin
                            r_mins <= ms_next(r_mins, MAX_MIN);
                            if (r_mins == MS_W'(MAX_MIN)) begin
                                r_hrs <= hr_next(r_hrs);
                                if (r_hrs == HR_W'(MAX_HR)) begin
                                    r_pm <= ~r_pm;
                                end
                            end
                        end
                    end
                    // Later assignment wins: entering set mode clears secs even on a tick edge.
                    if (w_mode_p) begin
                        r_state   <= SET_HRS;
                        r_set_hrs <= 1'b1;
                        r_secs    <= '0;
                    end
                end

                SET_HRS: begin
                    if (w_mode_p) begin
                        r_state    <= SET_MINS;
                        r_set_hrs  <= 1'b0;
                        r_set_mins <= 1'b1;
                    end else if (w_inc_p) begin
                        r_hrs <= hr_next(r_hrs);
                        if (r_hrs == HR_W'(MAX_HR)) begin
                            r_pm <= ~r_pm;
                        end
                    end
                end

                SET_MINS: begin
                    if (w_mode_p) begin
                        r_state    <= RUN;
                        r_set_mins <= 1'b0;
                    end else if (w_inc_p) begin
                        r_mins <= ms_next(r_mins, MAX_MIN);
                    end
                end

                default: begin
                    r_state    <= RUN;
                    r_set_hrs  <= 1'b0;
                    r_set_mins <= 1'b0;
                end
            endcase
        end
    end

    assign bus.hrs      = r_hrs;
    assign bus.mins     = r_mins;
    assign bus.secs     = r_secs;
    assign bus.pm       = r_pm;
    assign bus.set_hrs  = r_set_hrs;
    assign bus.set_mins = r_set_mins;
    assign bus.tick     = w_tick;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl with TICK_DIV=4: vector table through a scoreboard queue for the
// set-mode button sequences, hand-written sequences for reset, rollovers and collisions.
module tb_clock_set_ctrl;

    localparam int TICK_DIV = 4;
    localparam int CNT_W    = 3;

    typedef struct {
        logic       mode;
        logic       inc;
        logic [3:0] hrs;
        logic [5:0] mins;
        logic [5:0] secs;
        logic       pm;
        logic       sh;
        logic       sm;
    } vec_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    vec_t vecs[$];
    vec_t sb_q[$];

    clock_set_ctrl_if bus_if ();

    clock_set_ctrl #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic check_time(input string name, input int h, input int m, input int s, input int p);
        check({name, ".hrs"},  int'(bus_if.hrs),  h);
        check({name, ".mins"}, int'(bus_if.mins), m);
        check({name, ".secs"}, int'(bus_if.secs), s);
        check({name, ".pm"},   int'(bus_if.pm),   p);
    endtask

    task automatic check_mode(input string name, input int sh, input int sm);
        check({name, ".set_hrs"},  int'(bus_if.set_hrs),  sh);
        check({name, ".set_mins"}, int'(bus_if.set_mins), sm);
    endtask

    // Called at a falling edge: drive buttons, let one rising edge consume them, return at the next falling edge.
    task automatic cycle_in(input logic m, input logic i);
        bus_if.btn_mode = m;
        bus_if.btn_inc  = i;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic press_mode();
        cycle_in(1'b1, 1'b0);
        cycle_in(1'b0, 1'b0);
    endtask

    task automatic press_inc(input int n);
        for (int k = 0; k < n; k++) begin
            cycle_in(1'b0, 1'b1);
            cycle_in(1'b0, 1'b0);
        end
    endtask

    task automatic wait_tick_high();
        int k;
        k = 0;
        while (!bus_if.tick && k < 4 * TICK_DIV) begin
            cycle_in(1'b0, 1'b0);
            k++;
        end
        if (!bus_if.tick) begin
            n_checks++;
            $display("FAIL tick_timeout: no tick within %0d cycles", 4 * TICK_DIV);
        end
    endtask

    // Each tick is applied on the edge that ends its cycle.
    task automatic wait_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            wait_tick_high();
            cycle_in(1'b0, 1'b0);
        end
    endtask

    function automatic vec_t mk(input logic m, input logic i, input int h, input int mi,
                                input int s, input logic p, input logic sh, input logic sm);
        vec_t v;
        v.mode = m;
        v.inc  = i;
        v.hrs  = 4'(h);
        v.mins = 6'(mi);
        v.secs = 6'(s);
        v.pm   = p;
        v.sh   = sh;
        v.sm   = sm;
        return v;
    endfunction

    initial begin
        vec_t v;
        vec_t e;
        n_checks = 0;
        n_pass   = 0;

        // Starts in SET_HRS at 10:00:00 PM with both buttons released.
        vecs.push_back(mk(0, 1, 11, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 11, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 1,  0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0,  0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1,  1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0,  1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0,  1, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0,  1, 0, 0, 0, 0, 1));
        for (int i = 0; i < 20; i++) vecs.push_back(mk(0, 1, 1, 1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0,  1, 1, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0,  1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,  1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0,  1, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0,  1, 1, 0, 0, 1, 0));
        vecs.push_back(mk(1, 1,  1, 1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0,  1, 1, 0, 0, 0, 1));

        rst             = 1'b0;
        bus_if.btn_mode = 1'b0;
        bus_if.btn_inc  = 1'b0;
        @(negedge clk);
        cycle_in(1'b0, 1'b0);
        cycle_in(1'b0, 1'b0);
        check_time("por", 0, 0, 0, 0);
        check_mode("por", 0, 0);
        check("por.tick", int'(bus_if.tick), 0);

        // First tick lands in the fourth cycle after release.
        rst = 1'b1;
        cycle_in(1'b0, 1'b0);
        check("rel.tick1", int'(bus_if.tick), 0);
        cycle_in(1'b0, 1'b0);
        check("rel.tick2", int'(bus_if.tick), 0);
        cycle_in(1'b0, 1'b0);
        check("rel.tick3", int'(bus_if.tick), 1);
        for (int i = 0; i < 7; i++) cycle_in(1'b0, 1'b0);
        check_time("run2", 0, 0, 2, 0);

        rst = 1'b0;
        cycle_in(1'b0, 1'b0);
        check_time("midrst", 0, 0, 0, 0);
        check_mode("midrst", 0, 0);
        check("midrst.tick", int'(bus_if.tick), 0);
        rst = 1'b1;

        // Preload 3:58 through the set path.
        press_mode();
        check_mode("pre.sh", 1, 0);
        press_inc(3);
        press_mode();
        press_inc(58);
        check_time("pre358", 3, 58, 0, 0);
        check_mode("pre.sm", 0, 1);
        press_mode();
        check_mode("pre.run", 0, 0);

        wait_ticks(59);
        check_time("r35859", 3, 58, 59, 0);
        wait_ticks(1);
        check_time("r35900", 3, 59, 0, 0);
        wait_ticks(59);
        check_time("r35959", 3, 59, 59, 0);
        wait_ticks(1);
        check_time("r40000", 4, 0, 0, 0);

        // Half-day rollover from 11:59:58 AM.
        press_mode();
        press_inc(7);
        press_mode();
        press_inc(59);
        check_time("pre1159", 11, 59, 0, 0);
        press_mode();
        wait_ticks(58);
        check_time("h115958", 11, 59, 58, 0);
        wait_ticks(1);
        check_time("h115959", 11, 59, 59, 0);
        wait_ticks(1);
        check_time("h000000", 0, 0, 0, 1);

        wait_ticks(3);
        check_time("pm3s", 0, 0, 3, 1);
        press_mode();
        check_time("set.entry", 0, 0, 0, 1);
        check_mode("set.entry", 1, 0);
        press_inc(10);
        check_time("set.h10", 10, 0, 0, 1);

        foreach (vecs[i]) begin
            v = vecs[i];
            sb_q.push_back(v);
            cycle_in(v.mode, v.inc);
            e = sb_q.pop_front();
            check($sformatf("vec%0d.hrs", i),  int'(bus_if.hrs),      int'(e.hrs));
            check($sformatf("vec%0d.mins", i), int'(bus_if.mins),     int'(e.mins));
            check($sformatf("vec%0d.secs", i), int'(bus_if.secs),     int'(e.secs));
            check($sformatf("vec%0d.pm", i),   int'(bus_if.pm),       int'(e.pm));
            check($sformatf("vec%0d.sh", i),   int'(bus_if.set_hrs),  int'(e.sh));
            check($sformatf("vec%0d.sm", i),   int'(bus_if.set_mins), int'(e.sm));
        end

        // Minute wrap in SET_MINS does not carry into hours.
        press_inc(58);
        check_time("mw59", 1, 59, 0, 0);
        press_inc(1);
        check_time("mw00", 1, 0, 0, 0);
        check_mode("mw", 0, 1);

        // Back to RUN: prescaler restarted, first increment four cycles after entry.
        cycle_in(1'b1, 1'b0);
        check_mode("resume", 0, 0);
        check("resume.tick0", int'(bus_if.tick), 0);
        cycle_in(1'b0, 1'b0);
        cycle_in(1'b0, 1'b0);
        check("resume.tick2", int'(bus_if.tick), 0);
        cycle_in(1'b0, 1'b0);
        check("resume.tick3", int'(bus_if.tick), 1);
        check("resume.secs3", int'(bus_if.secs), 0);
        cycle_in(1'b0, 1'b0);
        check_time("resume4", 1, 0, 1, 0);

        // Mode press on the same edge as a tick at secs=30.
        wait_ticks(29);
        check_time("col30", 1, 0, 30, 0);
        wait_tick_high();
        cycle_in(1'b1, 1'b0);
        check_time("coltick", 1, 0, 0, 0);
        check_mode("coltick", 1, 0);
        cycle_in(1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
